// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: datapath widths, opcodes and the
// reservation-station entry layout used by the RS, FU and CDB arbiter.
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;
    localparam int INST_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    typedef struct packed {
        logic              busy;
        logic [INST_W-1:0] inst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
        logic              qj_valid;
        logic              qk_valid;
    } rs_entry_t;

endpackage

// File: rtl/rs_ready_select.sv
// Lowest-index priority picker over the per-entry ready bits.
module rs_ready_select #(
    parameter int DEPTH = 3
) (
    input  logic [DEPTH-1:0]         ready,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] index
);

    localparam int IDX_W = $clog2(DEPTH);

    // Scan from the youngest down so the oldest ready entry wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: holds issued instructions until
// both operands are present, snoops the CDB, and dispatches the oldest
// ready entry to a single downstream functional unit.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [INST_W-1:0]          issue_inst,
    input  logic [TAG_W-1:0]           issue_tag,
    input  logic [DATA_W-1:0]          issue_vj,
    input  logic [DATA_W-1:0]          issue_vk,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic [TAG_W-1:0]           issue_qk,
    input  logic                       issue_qj_valid,
    input  logic                       issue_qk_valid,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    input  logic                       fu_ready,
    output logic                       dispatch_valid,
    output logic [INST_W-1:0]          dispatch_inst,
    output logic [TAG_W-1:0]           dispatch_tag,
    output logic [DATA_W-1:0]          dispatch_r1,
    output logic [DATA_W-1:0]          dispatch_r2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entries     [DEPTH];
    rs_entry_t        entries_nxt [DEPTH];
    rs_entry_t        above       [DEPTH];
    rs_entry_t        incoming;
    logic [DEPTH-1:0] ready;
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic             do_issue;
    logic             do_dispatch;
    logic [CNT_W-1:0] wr_idx;

    // A pending operand whose tag is on the CDB takes the broadcast value.
    function automatic rs_entry_t snoop(input rs_entry_t e, input logic cv,
                                        input logic [TAG_W-1:0] ct,
                                        input logic [DATA_W-1:0] cval);
        rs_entry_t r;
        r = e;
        if (cv && r.busy && r.qj_valid && (r.qj == ct)) begin
            r.vj       = cval;
            r.qj_valid = 1'b0;
        end
        if (cv && r.busy && r.qk_valid && (r.qk == ct)) begin
            r.vk       = cval;
            r.qk_valid = 1'b0;
        end
        return r;
    endfunction

    // Ready is judged from registered state only, never from this cycle's CDB.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = entries[i].busy && !entries[i].qj_valid && !entries[i].qk_valid;
        end
    end

    rs_ready_select #(.DEPTH(DEPTH)) u_select (
        .ready (ready),
        .found (found),
        .index (sel_idx)
    );

    // No lookahead: a full station refuses issue even while dispatching.
    assign issue_ready = (count < CNT_W'(DEPTH));
    assign do_issue    = issue_valid && issue_ready;
    assign do_dispatch = fu_ready && !dispatch_valid && found;
    assign wr_idx      = count - CNT_W'(do_dispatch);

    // New entry from the issue stage, with same-cycle CDB bypass applied.
    always_comb begin
        incoming          = '0;
        incoming.busy     = 1'b1;
        incoming.inst     = issue_inst;
        incoming.tag      = issue_tag;
        incoming.vj       = issue_vj;
        incoming.vk       = issue_vk;
        incoming.qj       = issue_qj;
        incoming.qk       = issue_qk;
        incoming.qj_valid = issue_qj_valid;
        incoming.qk_valid = issue_qk_valid;
        incoming          = snoop(incoming, cdb_valid, cdb_tag, cdb_value);
    end

    // Each slot's upper neighbour; the top slot collapses to empty.
    always_comb begin
        above[DEPTH-1] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            above[i-1] = entries[i];
        end
    end

    // Collapse past the dispatched slot, snoop, then append the new entry.
    always_comb begin
        rs_entry_t e;
        for (int i = 0; i < DEPTH; i++) begin
            e = (do_dispatch && (i >= int'(sel_idx))) ? above[i] : entries[i];
            e = snoop(e, cdb_valid, cdb_tag, cdb_value);
            if (do_issue && (int'(wr_idx) == i)) begin
                e = incoming;
            end
            entries_nxt[i] = e;
        end
    end

    // Entry storage; reset only needs to clear the busy bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_nxt[i];
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(do_issue) - CNT_W'(do_dispatch);
        end
    end

    // Registered dispatch port; valid is a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            dispatch_valid <= 1'b0;
            dispatch_inst  <= '0;
            dispatch_tag   <= '0;
            dispatch_r1    <= '0;
            dispatch_r2    <= '0;
        end else begin
            dispatch_valid <= do_dispatch;
            if (do_dispatch) begin
                dispatch_inst <= entries[sel_idx].inst;
                dispatch_tag  <= entries[sel_idx].tag;
                dispatch_r1   <= entries[sel_idx].vk;
                dispatch_r2   <= entries[sel_idx].vj;
            end
        end
    end

endmodule
